ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction fetch stage directly upstream of the decode/execute stage.
- Generates word-addressed fetch PCs and issues single-outstanding requests to instruction memory.
- Buffers returned {pc, instruction} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Applies PC-relative branch redirects (pc + signed 5-bit target) coming back from the processor, flushing stale work.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_req  out  1  fetch request valid
mem_addr  out  32  word address of request; stable while mem_req=1 and mem_gnt=0
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  read data valid; responses in order, >= 1 cycle after grant
mem_rdata  in  32  instruction word
dec_valid  out  1  FIFO head valid
dec_instr  out  32  head instruction
dec_pc  out  32  PC of head instruction
dec_ready  in  1  decode consumes head when dec_valid & dec_ready
br_valid  in  1  taken-branch redirect, one-cycle pulse
br_pc  in  32  PC of the branch instruction
br_offset  in  5  signed branch target offset
stat_fetched  out  32  responses pushed into FIFO (see optional feature)
stat_flushed  out  32  instructions discarded by redirects (see optional feature)

Behaviour:
- Reset (rst_n=0, async):
  - fetch_pc=RESET_PC; FIFO empty; state IDLE.
  - mem_req=0, dec_valid=0, dec_instr=0, dec_pc=0, stats=0.
- Arithmetic:
  - redirect PC = br_pc + sign_extend(br_offset), modulo 2^32.
  - Sequential fetch_pc increments by 1 and wraps 32'hFFFF_FFFF -> 0.
- FSM, three states:
  - IDLE:
    - mem_req = (count < DEPTH) & ~br_valid; mem_addr = fetch_pc.
    - On mem_req & mem_gnt: latch req_pc = fetch_pc, fetch_pc += 1, go to WAIT.
    - mem_rvalid in IDLE is ignored.
  - WAIT:
    - mem_req=0.
    - On mem_rvalid: push {req_pc, mem_rdata}, go to IDLE. The next request can be issued no earlier than the following cycle.
  - DISCARD:
    - mem_req=0.
    - On mem_rvalid: drop the data, go to IDLE.
- No overflow possible: a request is issued only when count < DEPTH, and only pops occur until its response, so the push always fits.
- FIFO:
  - dec_valid = (count != 0) & ~br_valid.
  - dec_instr and dec_pc come from registered head storage; they hold their last value when empty.
  - Pop on dec_valid & dec_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Zero-latency bypass is not supported: a response is visible on dec_* the cycle after mem_rvalid.
- Redirect (br_valid=1), highest priority:
  - fetch_pc = redirect PC.
  - FIFO count forced to 0; stat_flushed += count, plus 1 if an in-flight response is dropped.
  - No decode transfer occurs this cycle (dec_valid forced 0).
  - IDLE: no request issued this cycle; stay in IDLE.
  - WAIT with mem_rvalid same cycle: data dropped, go to IDLE.
  - WAIT without mem_rvalid: go to DISCARD.
  - DISCARD: remain in DISCARD, or go to IDLE if mem_rvalid arrives the same cycle.
  - Back-to-back br_valid pulses: the last one wins.
- Reset mid-operation: all state returns to reset values. A memory response arriving after reset is released lands in IDLE and is ignored.

Optional Feature:
- Macro IFETCH_STATS_EN.
- Defined:
  - stat_fetched increments on every FIFO push.
  - stat_flushed accumulates discarded instructions as defined above.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: counters are not instantiated; stat_fetched and stat_flushed are tied to 0. Functional behaviour is otherwise identical.

Test Plan:
- Reset release, mem_gnt=1, 1-cycle rvalid returning 32'hA0+addr, dec_ready=1 -> mem_addr 0,1,2,3 in order; dec_pc/dec_instr pairs (0,A0),(1,A1),...; mem_req on alternate cycles.
- dec_ready=0 with DEPTH=4 -> exactly 4 requests, then mem_req held 0; raise dec_ready -> entries pop in order and fetching resumes at addr 4.
- br_valid with br_pc=10, br_offset=5'b11101 (-3) while FIFO holds 3 entries -> FIFO empty next cycle; next mem_addr=7; stat_flushed=3 (with IFETCH_STATS_EN).
- Redirect while in WAIT, mem_rvalid 2 cycles later with data 32'hDEAD -> 32'hDEAD never appears on dec_instr; first new request to redirect PC issued after the dropped response.
- RESET_PC=32'hFFFF_FFFE, no redirects -> fetch addresses FFFF_FFFE, FFFF_FFFF, 0000_0000.
- Assert rst_n=0 mid-WAIT, release, then a stale rvalid arrives -> dec_valid stays 0; first request to RESET_PC proceeds normally.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// Bundle of memory, decode, redirect and statistics signals for ifetch_queue.
// master = fetch unit side, slave = environment (memory / decode / branch unit).
interface ifetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        br_valid;
  logic [31:0] br_pc;
  logic [4:0]  br_offset;
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output dec_valid, dec_instr, dec_pc,
    input  dec_ready,
    input  br_valid, br_pc, br_offset,
    output stat_fetched, stat_flushed
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  dec_valid, dec_instr, dec_pc,
    output dec_ready,
    output br_valid, br_pc, br_offset,
    input  stat_fetched, stat_flushed
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: single-outstanding memory fetch, {pc, instr} FIFO to decode,
// PC-relative redirect with flush. Optional statistics counters enabled by IFETCH_STATS_EN.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst_n,
  ifetch_queue_if.master bus_io
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      dec_pc_q, dec_pc_d;
  logic [31:0]      dec_instr_q, dec_instr_d;
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic [31:0]      br_target;
  logic             req;
  logic             push;
  logic             pop;
  logic             drop_inflight;
  logic             dec_valid;
  logic [PTR_W-1:0] head_idx;
  logic [CNT_W-1:0] remain;

  assign br_target = bus_io.br_pc + {{27{bus_io.br_offset[4]}}, bus_io.br_offset};
  assign dec_valid = (count_q != '0) & ~bus_io.br_valid;
  assign pop       = dec_valid & bus_io.dec_ready;

  // Request gating includes rst_n so the bus stays quiet while reset is held
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    req           = 1'b0;
    push          = 1'b0;
    drop_inflight = 1'b0;
    case (state_q)
      IDLE: begin
        req = rst_n & ~bus_io.br_valid & (count_q < FULL);
        if (req && bus_io.mem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (bus_io.br_valid) begin
          drop_inflight = 1'b1;
          state_d       = bus_io.mem_rvalid ? IDLE : DISCARD;
        end else if (bus_io.mem_rvalid) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (bus_io.mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus_io.br_valid) fetch_pc_d = br_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  assign head_idx = rd_ptr_q + PTR_W'(pop);
  assign remain   = count_q - CNT_W'(pop);

  // The dec_* registers always hold the next head, so decode sees registered data
  always_comb begin
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    dec_pc_d    = dec_pc_q;
    dec_instr_d = dec_instr_q;
    if (bus_io.br_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (remain != '0) begin
        dec_pc_d    = pc_mem[head_idx];
        dec_instr_d = instr_mem[head_idx];
      end else if (push) begin
        dec_pc_d    = req_pc_q;
        dec_instr_d = bus_io.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      dec_pc_q    <= '0;
      dec_instr_q <= '0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      dec_pc_q    <= dec_pc_d;
      dec_instr_q <= dec_instr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_pc_q;
      instr_mem[wr_ptr_q] <= bus_io.mem_rdata;
    end
  end

`ifdef IFETCH_STATS_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] flushed_q, flushed_d;

  // A redirect discards every queued entry plus the in-flight response if one is dropped
  always_comb begin
    fetched_d = fetched_q;
    flushed_d = flushed_q;
    if (push) fetched_d = fetched_q + 32'd1;
    if (bus_io.br_valid) flushed_d = flushed_q + 32'(count_q) + 32'(drop_inflight);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign bus_io.stat_fetched = fetched_q;
  assign bus_io.stat_flushed = flushed_q;
`else
  assign bus_io.stat_fetched = 32'd0;
  assign bus_io.stat_flushed = 32'd0;
`endif

  assign bus_io.mem_req   = req;
  assign bus_io.mem_addr  = fetch_pc_q;
  assign bus_io.dec_valid = dec_valid;
  assign bus_io.dec_pc    = dec_pc_q;
  assign bus_io.dec_instr = dec_instr_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: directed scenarios plus a randomized run against a
// queue-based transaction model of the fetch stage.
module tb_ifetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ifetch_queue_if bus ();
  ifetch_queue_if wbus ();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .bus_io(bus)
  );

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus_io(wbus)
  );

  int nTests = 0;
  int nFail  = 0;

  logic        sReq, sDv;
  logic [31:0] sAddr, sPc, sInstr, sFetched, sFlushed;

  task automatic applyReset();
    rst_n = 1'b0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.dec_ready = 1'b0;
    bus.br_valid = 1'b0; bus.br_pc = '0; bus.br_offset = '0;
    wbus.mem_gnt = 1'b0; wbus.mem_rvalid = 1'b0; wbus.mem_rdata = '0; wbus.dec_ready = 1'b0;
    wbus.br_valid = 1'b0; wbus.br_pc = '0; wbus.br_offset = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic sampleNeg();
    @(negedge clk);
    sReq = bus.mem_req; sAddr = bus.mem_addr; sDv = bus.dec_valid;
    sPc = bus.dec_pc; sInstr = bus.dec_instr;
    sFetched = bus.stat_fetched; sFlushed = bus.stat_flushed;
  endtask

  // Advance one cycle; optionally answer the request granted in the cycle just ended
  task automatic toNext(input bit autoResp);
    @(posedge clk);
    #1;
    if (autoResp) begin
      bus.mem_rvalid = sReq & bus.mem_gnt;
      bus.mem_rdata  = 32'hA0 + sAddr;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.dec_ready = 1'b1;
    bus.br_valid = 1'b0; bus.br_pc = '0; bus.br_offset = '0;
    wbus.mem_gnt = 1'b0; wbus.mem_rvalid = 1'b0; wbus.mem_rdata = '0; wbus.dec_ready = 1'b0;
    wbus.br_valid = 1'b0; wbus.br_pc = '0; wbus.br_offset = '0;
    repeat (2) @(posedge clk);
    sampleNeg();
    nTests++; if (sReq !== 1'b0) begin nFail++; $display("[TB] FAIL reset_mem_req got %b want 0", sReq); end
    nTests++; if (sDv !== 1'b0) begin nFail++; $display("[TB] FAIL reset_dec_valid got %b want 0", sDv); end
    nTests++; if (sPc !== 32'd0) begin nFail++; $display("[TB] FAIL reset_dec_pc got %h want 0", sPc); end
    nTests++; if (sInstr !== 32'd0) begin nFail++; $display("[TB] FAIL reset_dec_instr got %h want 0", sInstr); end
    nTests++; if (sFetched !== 32'd0) begin nFail++; $display("[TB] FAIL reset_stat_fetched got %h want 0", sFetched); end
    nTests++; if (sFlushed !== 32'd0) begin nFail++; $display("[TB] FAIL reset_stat_flushed got %h want 0", sFlushed); end
    @(posedge clk); #1 rst_n = 1'b1;
    sampleNeg();
    nTests++; if (sReq !== 1'b1 || sAddr !== 32'd0) begin nFail++; $display("[TB] FAIL reset_first_req got req=%b addr=%h want req=1 addr=0", sReq, sAddr); end
  endtask

  task automatic test_sequential();
    int k = 0;
    logic [31:0] nextAddr = 32'd0;
    bit expR;
    applyReset();
    bus.mem_gnt = 1'b1; bus.dec_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      sampleNeg();
      expR = (c % 2 == 0);
      nTests++; if (sReq !== expR) begin nFail++; $display("[TB] FAIL seq_req_alternate cycle %0d got %b want %b", c, sReq, expR); end
      if (sReq) begin
        nTests++; if (sAddr !== nextAddr) begin nFail++; $display("[TB] FAIL seq_addr got %h want %h", sAddr, nextAddr); end
        nextAddr++;
      end
      if (sDv) begin
        nTests++; if (sPc !== 32'(k) || sInstr !== 32'hA0 + 32'(k)) begin nFail++; $display("[TB] FAIL seq_pair got (%h,%h) want (%h,%h)", sPc, sInstr, 32'(k), 32'hA0 + 32'(k)); end
        k++;
      end
      toNext(1'b1);
    end
    nTests++; if (k !== 7) begin nFail++; $display("[TB] FAIL seq_pair_count got %0d want 7", k); end
  endtask

  task automatic test_backpressure();
    int nReq = 0;
    int popped = 0;
    bit seenReq = 1'b0;
    applyReset();
    bus.mem_gnt = 1'b1; bus.dec_ready = 1'b0;
    for (int c = 0; c < 14; c++) begin
      sampleNeg();
      if (sReq) begin
        nTests++; if (sAddr !== 32'(nReq)) begin nFail++; $display("[TB] FAIL bp_addr got %h want %h", sAddr, 32'(nReq)); end
        nReq++;
      end
      toNext(1'b1);
    end
    nTests++; if (nReq !== DEPTH) begin nFail++; $display("[TB] FAIL bp_req_count got %0d want %0d", nReq, DEPTH); end
    bus.dec_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      sampleNeg();
      if (sDv) begin
        nTests++; if (sPc !== 32'(popped) || sInstr !== 32'hA0 + 32'(popped)) begin nFail++; $display("[TB] FAIL bp_pop got (%h,%h) want (%h,%h)", sPc, sInstr, 32'(popped), 32'hA0 + 32'(popped)); end
        popped++;
      end
      if (sReq && !seenReq) begin
        seenReq = 1'b1;
        nTests++; if (sAddr !== 32'd4) begin nFail++; $display("[TB] FAIL bp_resume_addr got %h want 4", sAddr); end
      end
      toNext(1'b1);
    end
    nTests++; if (!seenReq || popped < 5) begin nFail++; $display("[TB] FAIL bp_resume got resumed=%b pops=%0d want resumed=1 pops>=5", seenReq, popped); end
  endtask

  task automatic test_redirect_flush();
    int nReq = 0;
    bit seen = 1'b0;
    applyReset();
    bus.mem_gnt = 1'b1; bus.dec_ready = 1'b0;
    for (int c = 0; c < 20 && nReq < 3; c++) begin
      sampleNeg();
      if (sReq) nReq++;
      toNext(1'b1);
      if (nReq == 3) bus.mem_gnt = 1'b0;
    end
    sampleNeg();
    toNext(1'b1);
    bus.br_valid = 1'b1; bus.br_pc = 32'd10; bus.br_offset = 5'b11101;
    sampleNeg();
    nTests++; if (sDv !== 1'b0 || sReq !== 1'b0) begin nFail++; $display("[TB] FAIL flush_br_cycle got dv=%b req=%b want 0/0", sDv, sReq); end
    toNext(1'b0);
    bus.br_valid = 1'b0;
    sampleNeg();
    nTests++; if (sDv !== 1'b0) begin nFail++; $display("[TB] FAIL flush_empty got dv=%b want 0", sDv); end
    nTests++; if (sReq !== 1'b1 || sAddr !== 32'd7) begin nFail++; $display("[TB] FAIL flush_next_addr got req=%b addr=%h want req=1 addr=7", sReq, sAddr); end
`ifdef IFETCH_STATS_EN
    nTests++; if (sFlushed !== 32'd3 || sFetched !== 32'd3) begin nFail++; $display("[TB] FAIL flush_stats got fl=%0d fe=%0d want 3/3", sFlushed, sFetched); end
`endif
    toNext(1'b1);
    bus.mem_gnt = 1'b1; bus.dec_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sampleNeg();
      if (sDv && !seen) begin
        seen = 1'b1;
        nTests++; if (sPc !== 32'd7 || sInstr !== 32'hA7) begin nFail++; $display("[TB] FAIL flush_first_new got (%h,%h) want (7,a7)", sPc, sInstr); end
      end
      toNext(1'b1);
    end
    nTests++; if (!seen) begin nFail++; $display("[TB] FAIL flush_new_entry got none want one"); end
  endtask

  task automatic test_redirect_wait();
    bit seen = 1'b0;
    applyReset();
    bus.mem_gnt = 1'b1; bus.dec_ready = 1'b1;
    sampleNeg();
    toNext(1'b0);
    bus.br_valid = 1'b1; bus.br_pc = 32'd20; bus.br_offset = 5'd0;
    sampleNeg();
    nTests++; if (sReq !== 1'b0 || sDv !== 1'b0) begin nFail++; $display("[TB] FAIL rw_br_cycle got req=%b dv=%b want 0/0", sReq, sDv); end
    toNext(1'b0);
    bus.br_valid = 1'b0;
    sampleNeg();
    nTests++; if (sReq !== 1'b0) begin nFail++; $display("[TB] FAIL rw_discard_req got %b want 0", sReq); end
    toNext(1'b0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD;
    sampleNeg();
    nTests++; if (sReq !== 1'b0) begin nFail++; $display("[TB] FAIL rw_drop_cycle_req got %b want 0", sReq); end
    toNext(1'b0);
    bus.mem_rvalid = 1'b0;
    sampleNeg();
    nTests++; if (sReq !== 1'b1 || sAddr !== 32'd20 || sDv !== 1'b0) begin nFail++; $display("[TB] FAIL rw_new_req got req=%b addr=%h dv=%b want 1/14/0", sReq, sAddr, sDv); end
`ifdef IFETCH_STATS_EN
    nTests++; if (sFlushed !== 32'd1) begin nFail++; $display("[TB] FAIL rw_stat_flushed got %0d want 1", sFlushed); end
`endif
    for (int c = 0; c < 8; c++) begin
      toNext(1'b1);
      sampleNeg();
      nTests++; if (sInstr === 32'hDEAD) begin nFail++; $display("[TB] FAIL rw_stale_data got %h want not dead", sInstr); end
      if (sDv && !seen) begin
        seen = 1'b1;
        nTests++; if (sPc !== 32'd20 || sInstr !== 32'hB4) begin nFail++; $display("[TB] FAIL rw_first_pair got (%h,%h) want (14,b4)", sPc, sInstr); end
      end
    end
    nTests++; if (!seen) begin nFail++; $display("[TB] FAIL rw_no_entry got none want one"); end
  endtask

  task automatic test_reset_mid_wait();
    bit seenR = 1'b0, seenD = 1'b0;
    applyReset();
    bus.mem_gnt = 1'b1; bus.dec_ready = 1'b1;
    sampleNeg();
    toNext(1'b0);
    rst_n = 1'b0; bus.mem_gnt = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBEEF;
    sampleNeg();
    nTests++; if (sDv !== 1'b0 || sReq !== 1'b1 || sAddr !== 32'd0) begin nFail++; $display("[TB] FAIL rmw_stale_cycle got dv=%b req=%b addr=%h want 0/1/0", sDv, sReq, sAddr); end
    toNext(1'b0);
    bus.mem_rvalid = 1'b0;
    sampleNeg();
    nTests++; if (sDv !== 1'b0) begin nFail++; $display("[TB] FAIL rmw_stale_ignored got dv=%b want 0", sDv); end
    toNext(1'b0);
    bus.mem_gnt = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sampleNeg();
      if (sReq && !seenR) begin
        seenR = 1'b1;
        nTests++; if (sAddr !== 32'd0) begin nFail++; $display("[TB] FAIL rmw_first_addr got %h want 0", sAddr); end
      end
      if (sDv && !seenD) begin
        seenD = 1'b1;
        nTests++; if (sPc !== 32'd0 || sInstr !== 32'hA0) begin nFail++; $display("[TB] FAIL rmw_first_pair got (%h,%h) want (0,a0)", sPc, sInstr); end
      end
      toNext(1'b1);
    end
    nTests++; if (!seenR || !seenD) begin nFail++; $display("[TB] FAIL rmw_progress got req=%b dec=%b want 1/1", seenR, seenD); end
  endtask

  task automatic test_wrap();
    logic [31:0] expW [3];
    int idx = 0;
    logic wReq;
    logic [31:0] wAddr;
    expW[0] = 32'hFFFF_FFFE; expW[1] = 32'hFFFF_FFFF; expW[2] = 32'h0000_0000;
    applyReset();
    wbus.mem_gnt = 1'b1; wbus.dec_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      wReq = wbus.mem_req; wAddr = wbus.mem_addr;
      if (wReq && idx < 3) begin
        nTests++; if (wAddr !== expW[idx]) begin nFail++; $display("[TB] FAIL wrap_addr got %h want %h", wAddr, expW[idx]); end
        idx++;
      end
      @(posedge clk); #1;
      wbus.mem_rvalid = wReq; wbus.mem_rdata = 32'hA0 + wAddr;
    end
    nTests++; if (idx !== 3) begin nFail++; $display("[TB] FAIL wrap_req_count got %0d want 3", idx); end
  endtask

  // Transaction model: a queue of {pc, instr}, one outstanding request, counters from the rules
  task automatic test_random(input int cycles);
    logic [31:0] qPc[$], qIn[$];
    bit outst = 1'b0, drop = 1'b0, expReq, expDv, issued;
    logic [31:0] oAddr = '0, mPc = '0, lastPc = '0, lastIn = '0, mFetched = '0, mFlushed = '0;
    logic [31:0] expFe, expFl;
    int age = 0, lat = 1;
    applyReset();
    for (int c = 0; c < cycles; c++) begin
      bus.mem_gnt    = ($urandom_range(0, 3) != 0);
      bus.dec_ready  = ($urandom_range(0, 2) != 0);
      bus.br_valid   = ($urandom_range(0, 11) == 0);
      bus.br_pc      = $urandom;
      bus.br_offset  = 5'($urandom);
      bus.mem_rvalid = outst && (age >= lat);
      bus.mem_rdata  = $urandom;
      expReq = !outst && (qPc.size() < DEPTH) && !bus.br_valid;
      expDv  = (qPc.size() != 0) && !bus.br_valid;
`ifdef IFETCH_STATS_EN
      expFe = mFetched; expFl = mFlushed;
`else
      expFe = 32'd0; expFl = 32'd0;
`endif
      sampleNeg();
      nTests++; if (sReq !== expReq) begin nFail++; $display("[TB] FAIL rnd_mem_req cycle %0d got %b want %b", c, sReq, expReq); end
      if (expReq) begin
        nTests++; if (sAddr !== mPc) begin nFail++; $display("[TB] FAIL rnd_mem_addr cycle %0d got %h want %h", c, sAddr, mPc); end
      end
      nTests++; if (sDv !== expDv) begin nFail++; $display("[TB] FAIL rnd_dec_valid cycle %0d got %b want %b", c, sDv, expDv); end
      nTests++; if (sPc !== lastPc || sInstr !== lastIn) begin nFail++; $display("[TB] FAIL rnd_dec_head cycle %0d got (%h,%h) want (%h,%h)", c, sPc, sInstr, lastPc, lastIn); end
      nTests++; if (sFetched !== expFe || sFlushed !== expFl) begin nFail++; $display("[TB] FAIL rnd_stats cycle %0d got (%0d,%0d) want (%0d,%0d)", c, sFetched, sFlushed, expFe, expFl); end
      @(posedge clk);
      issued = 1'b0;
      if (bus.br_valid) begin
        mFlushed += 32'(qPc.size()) + 32'(outst && !drop);
        qPc.delete(); qIn.delete();
        if (outst) begin
          if (bus.mem_rvalid) outst = 1'b0;
          else drop = 1'b1;
        end
        mPc = bus.br_pc + 32'($signed(bus.br_offset));
      end else begin
        if (expDv && bus.dec_ready) begin
          void'(qPc.pop_front()); void'(qIn.pop_front());
        end
        if (outst && bus.mem_rvalid) begin
          if (!drop) begin
            qPc.push_back(oAddr); qIn.push_back(bus.mem_rdata); mFetched++;
          end
          outst = 1'b0;
        end
        if (expReq && bus.mem_gnt) begin
          outst = 1'b1; drop = 1'b0; oAddr = mPc; mPc++; issued = 1'b1;
          age = 1; lat = $urandom_range(1, 3);
        end
      end
      if (!issued && outst) age++;
      if (qPc.size() != 0) begin
        lastPc = qPc[0]; lastIn = qIn[0];
      end
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    #2;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_flush();
    test_redirect_wait();
    test_reset_mid_wait();
    test_wrap();
    test_random(800);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
